gram_engine: RTL

GRAM_ENGINE -- requirements
Module: gram_engine

---
 rtl/gram_engine.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gram_engine.sv
// Gram-matrix engine: one signed multiply-accumulate per cycle over the lower
// triangle of H*H^T, mirrored into a symmetric result published on completion.
module gram_engine #(
    parameter int N_VEC = 4,
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int ACC_W = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_VEC*DIM*WIDTH-1:0]     h_flat,
    input  logic [WIDTH-1:0]               diag_load,
    output logic                           busy,
    output logic                           done,
    output logic [N_VEC*N_VEC*ACC_W-1:0]   g_flat,
    output logic [1:0]                     dbg_state
);

    localparam int IW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
    localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q;
    logic [N_VEC*DIM*WIDTH-1:0]      h_q;
    logic [WIDTH-1:0]                diag_q;
    logic [ACC_W-1:0]                acc_q;
    logic [IW-1:0]                   i_q;
    logic [IW-1:0]                   j_q;
    logic [KW-1:0]                   k_q;
    logic [N_VEC*N_VEC*ACC_W-1:0]    res_q;
    logic [N_VEC*N_VEC*ACC_W-1:0]    g_q;
    logic                            busy_q;
    logic                            done_q;

    logic signed [WIDTH-1:0]         a_s;
    logic signed [WIDTH-1:0]         b_s;
    logic signed [2*WIDTH-1:0]       prod;
    logic [ACC_W-1:0]                sum_d;
    logic [ACC_W-1:0]                fin_d;
    logic                            last_k;
    logic                            last_pair;
    logic [N_VEC*N_VEC*ACC_W-1:0]    res_d;

    // Datapath for the current (i, j, k); the finished sum is merged into
    // res_d so the final pair is already present when g_flat is loaded.
    always_comb begin
        a_s       = h_q[(int'(i_q) * DIM + int'(k_q)) * WIDTH +: WIDTH];
        b_s       = h_q[(int'(j_q) * DIM + int'(k_q)) * WIDTH +: WIDTH];
        prod      = a_s * b_s;
        sum_d     = acc_q + {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
        fin_d     = sum_d + ((i_q == j_q) ? {{(ACC_W - WIDTH){1'b0}}, diag_q} : '0);
        last_k    = (k_q == KW'(DIM - 1));
        last_pair = (i_q == IW'(N_VEC - 1)) && (j_q == IW'(N_VEC - 1));
        res_d     = res_q;
        if (state_q == MAC && last_k) begin
            res_d[(int'(i_q) * N_VEC + int'(j_q)) * ACC_W +: ACC_W] = fin_d;
            res_d[(int'(j_q) * N_VEC + int'(i_q)) * ACC_W +: ACC_W] = fin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            diag_q  <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
            g_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= MAC;
                        h_q     <= h_flat;
                        diag_q  <= diag_load;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                MAC: begin
                    res_q <= res_d;
                    if (last_k) begin
                        acc_q <= '0;
                        k_q   <= '0;
                        // Row-major walk of the lower triangle: j runs 0..i.
                        if (j_q == i_q) begin
                            i_q <= i_q + IW'(1);
                            j_q <= '0;
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                        if (last_pair) begin
                            state_q <= DONE;
                            g_q     <= res_d;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        acc_q <= sum_d;
                        k_q   <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign g_flat    = g_q;
    assign dbg_state = state_q;

endmodule
